// File: rtl/counter_sequencer_pkg.sv
// Shared encodings for the run/stop/step counter sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package counter_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_FREE     = 2'b00;
  localparam logic [1:0] MODE_ONESHOT  = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;

endpackage

// File: rtl/counter_sequencer_if.sv
// Switch-bank commands in, light-bank status out, for the counter sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; switches are levels and lights are always valid.
interface counter_sequencer_if #(parameter int WIDTH = 4) ();

  logic             START;
  logic             STOP;
  logic             STEP;
  logic             LOAD;
  logic [1:0]       MODE;
  logic [WIDTH-1:0] LIMIT;
  logic [WIDTH-1:0] LOAD_VAL;
  logic [WIDTH-1:0] COUNT;
  logic             RUNNING;
  logic             DONE;
  logic             DIR;

  // Switch bank side: drives commands, reads lights.
  modport master (
    output START, STOP, STEP, LOAD, MODE, LIMIT, LOAD_VAL,
    input  COUNT, RUNNING, DONE, DIR
  );

  // Sequencer side.
  modport slave (
    input  START, STOP, STEP, LOAD, MODE, LIMIT, LOAD_VAL,
    output COUNT, RUNNING, DONE, DIR
  );

endinterface

// File: rtl/counter_sequencer_switch_edge_sync.sv
// Synchronises one switch level and emits a one-cycle pulse on its rising edge.
// Latency: input rising before edge k gives O_EVT high after edge k+SYNC_STAGES.
// Backpressure: none; a pulse is produced once per rising edge.
module switch_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic I,
  output logic O_EVT
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain, previous-value flop and registered rising-edge pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      O_EVT  <= 1'b0;
    end else begin
      for (int i = SYNC_STAGES - 1; i > 0; i--) begin
        sync_q[i] <= sync_q[i-1];
      end
      sync_q[0] <= I;
      prev_q    <= sync_q[SYNC_STAGES-1];
      O_EVT     <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Run/stop/step sequencer for a WIDTH-bit counter: free-run, one-shot, ping-pong.
// Latency: switch edge before clock edge k is acted on at edge k+SYNC_STAGES+1.
// Backpressure: none; simultaneous commands resolve STOP > LOAD > START > STEP.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  counter_sequencer_if.slave bus
);

  // The mask must outlast the flush of the synchronisers: a switch held high
  // across reset release shows up as a raw event on edge SYNC_STAGES+1 and
  // would be acted on at the next edge, so qualify events only from there on.
  localparam int MASK_LEN = SYNC_STAGES + 2;
  localparam int MW       = $clog2(MASK_LEN + 1);

  logic [MW-1:0]    mask_cnt_q;
  logic             armed;
  logic             start_raw, stop_raw, step_raw, load_raw;
  logic             start_e, stop_e, step_e, load_e;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] limit_q, limit_d;

  switch_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_start (.CLK(CLK), .RST_N(RST_N), .I(bus.START), .O_EVT(start_raw));
  switch_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_stop  (.CLK(CLK), .RST_N(RST_N), .I(bus.STOP),  .O_EVT(stop_raw));
  switch_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_step  (.CLK(CLK), .RST_N(RST_N), .I(bus.STEP),  .O_EVT(step_raw));
  switch_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load  (.CLK(CLK), .RST_N(RST_N), .I(bus.LOAD),  .O_EVT(load_raw));

  assign armed   = (mask_cnt_q == MW'(MASK_LEN));
  assign start_e = start_raw & armed;
  assign stop_e  = stop_raw  & armed;
  assign step_e  = step_raw  & armed;
  assign load_e  = load_raw  & armed;

  // Post-reset event mask: count up once and saturate.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mask_cnt_q <= '0;
    end else if (!armed) begin
      mask_cnt_q <= mask_cnt_q + MW'(1);
    end
  end

  // State, count, direction and latched mode/limit registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      dir_q   <= 1'b0;
      mode_q  <= MODE_FREE;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      limit_q <= limit_d;
    end
  end

  // Next-state and count datapath; the if/else order encodes command priority.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    limit_d = limit_q;
    case (state_q)
      ST_IDLE: begin
        if (stop_e) begin
          state_d = ST_IDLE;
        end else if (load_e) begin
          count_d = bus.LOAD_VAL;
        end else if (start_e) begin
          state_d = ST_RUN;
          mode_d  = bus.MODE;
          limit_d = bus.LIMIT;
          dir_d   = 1'b0;
        end else if (step_e) begin
          count_d = count_q + WIDTH'(1);
        end
      end
      ST_RUN: begin
        if (stop_e) begin
          state_d = ST_IDLE;
        end else if (load_e) begin
          count_d = bus.LOAD_VAL;
        end else if (start_e) begin
          mode_d  = bus.MODE;
          limit_d = bus.LIMIT;
          dir_d   = 1'b0;
        end else begin
          case (mode_q)
            MODE_ONESHOT: begin
              if (count_q == limit_q) state_d = ST_DONE;
              else                    count_d = count_q + WIDTH'(1);
            end
            MODE_PINGPONG: begin
              if (!dir_q) begin
                if (count_q >= limit_q) begin
                  // At 0 this only happens with a zero limit: park there.
                  if (count_q != '0) begin
                    dir_d   = 1'b1;
                    count_d = count_q - WIDTH'(1);
                  end
                end else begin
                  count_d = count_q + WIDTH'(1);
                end
              end else begin
                if (count_q == '0) begin
                  dir_d = 1'b0;
                  if (limit_q != '0) count_d = count_q + WIDTH'(1);
                end else begin
                  count_d = count_q - WIDTH'(1);
                end
              end
            end
            default: count_d = count_q + WIDTH'(1);
          endcase
        end
      end
      ST_DONE: begin
        if (stop_e) begin
          state_d = ST_IDLE;
        end else if (load_e) begin
          state_d = ST_IDLE;
          count_d = bus.LOAD_VAL;
        end else if (start_e) begin
          state_d = ST_RUN;
          count_d = '0;
          mode_d  = bus.MODE;
          limit_d = bus.LIMIT;
          dir_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.COUNT   = count_q;
  assign bus.RUNNING = (state_q == ST_RUN);
  assign bus.DONE    = (state_q == ST_DONE);
  assign bus.DIR     = dir_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with hand-computed expectations.
// Latency: press() returns just after the edge on which the command is acted.
// Backpressure: n/a.
module tb_counter_sequencer;

  logic CLK;
  logic RST_N;
  int   n_checks;
  int   n_fail;

  counter_sequencer_if #(.WIDTH(4)) bus ();

  counter_sequencer #(.WIDTH(4), .SYNC_STAGES(2)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // sw = {stop, load, start, step}; held for one edge, acted on 3 edges later.
  task automatic press(input logic [3:0] sw);
    bus.STOP  = sw[3];
    bus.LOAD  = sw[2];
    bus.START = sw[1];
    bus.STEP  = sw[0];
    tick(1);
    bus.STOP  = 1'b0;
    bus.LOAD  = 1'b0;
    bus.START = 1'b0;
    bus.STEP  = 1'b0;
    tick(3);
  endtask

  int unsigned pp_cnt [7] = '{1, 2, 3, 2, 1, 0, 1};
  int unsigned pp_dir [7] = '{0, 0, 0, 1, 1, 1, 0};

  initial begin
    int unsigned e;
    logic seen_run;
    n_checks     = 0;
    n_fail       = 0;
    RST_N        = 1'b1;
    bus.START    = 1'b1;
    bus.STOP     = 1'b0;
    bus.STEP     = 1'b0;
    bus.LOAD     = 1'b0;
    bus.MODE     = 2'b00;
    bus.LIMIT    = 4'd0;
    bus.LOAD_VAL = 4'd0;

    // Reset values, then START held high across release must not run.
    #2 RST_N = 1'b0;
    #1;
    check_val("rst_count",   bus.COUNT,   0);
    check_val("rst_running", bus.RUNNING, 0);
    check_val("rst_done",    bus.DONE,    0);
    check_val("rst_dir",     bus.DIR,     0);
    tick(3);
    #3 RST_N = 1'b1;
    seen_run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bus.RUNNING) seen_run = 1'b1;
    end
    check_val("mask_no_run", seen_run,  0);
    check_val("mask_count",  bus.COUNT, 0);
    bus.START = 1'b0;
    tick(3);
    bus.START = 1'b1;
    tick(3);
    check_val("start_lat_early", bus.RUNNING, 0);
    tick(1);
    check_val("start_lat_run",   bus.RUNNING, 1);
    check_val("start_count",     bus.COUNT,   0);
    bus.START = 1'b0;

    // Free-run wrap over 17 cycles, then STOP freezes the count.
    for (int i = 1; i <= 17; i++) begin
      tick(1);
      check_val($sformatf("free_%0d", i), bus.COUNT, i % 16);
    end
    press(4'b1000);
    check_val("stop_running", bus.RUNNING, 0);
    check_val("stop_count",   bus.COUNT,   4);
    tick(2);
    check_val("stop_frozen",  bus.COUNT,   4);

    // One-shot to 5 from 0.
    bus.LOAD_VAL = 4'd0;
    press(4'b0100);
    check_val("load0", bus.COUNT, 0);
    bus.MODE  = 2'b01;
    bus.LIMIT = 4'd5;
    press(4'b0010);
    check_val("os_start", bus.COUNT, 0);
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      check_val($sformatf("os_%0d", i), bus.COUNT, i);
    end
    tick(1);
    check_val("os_done",       bus.DONE,    1);
    check_val("os_done_run",   bus.RUNNING, 0);
    check_val("os_done_count", bus.COUNT,   5);
    tick(2);
    check_val("os_hold", bus.COUNT, 5);
    press(4'b0010);
    check_val("os_restart_run",   bus.RUNNING, 1);
    check_val("os_restart_count", bus.COUNT,   0);
    tick(6);
    check_val("os_done2", bus.DONE, 1);
    press(4'b0001);
    check_val("step_in_done_cnt",  bus.COUNT, 5);
    check_val("step_in_done_done", bus.DONE,  1);
    bus.LOAD_VAL = 4'd9;
    press(4'b0100);
    check_val("done_load_cnt",  bus.COUNT, 9);
    check_val("done_load_done", bus.DONE,  0);
    press(4'b0010);
    check_val("os9_start", bus.COUNT, 9);
    e = 9;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      e = (e + 1) % 16;
      check_val($sformatf("os9_%0d", i), bus.COUNT, e);
    end
    tick(1);
    check_val("os9_done",  bus.DONE,  1);
    check_val("os9_count", bus.COUNT, 5);

    // Ping-pong, limit 3, started from DONE.
    bus.MODE  = 2'b10;
    bus.LIMIT = 4'd3;
    press(4'b0010);
    check_val("pp_start_cnt", bus.COUNT, 0);
    check_val("pp_start_dir", bus.DIR,   0);
    for (int i = 0; i < 7; i++) begin
      tick(1);
      check_val($sformatf("pp_cnt_%0d", i), bus.COUNT, pp_cnt[i]);
      check_val($sformatf("pp_dir_%0d", i), bus.DIR,   pp_dir[i]);
    end
    press(4'b1000);
    check_val("pp_stop_cnt", bus.COUNT,   2);
    check_val("pp_stop_dir", bus.DIR,     1);
    check_val("pp_stop_run", bus.RUNNING, 0);
    bus.LOAD_VAL = 4'd0;
    press(4'b0100);
    bus.LIMIT = 4'd0;
    press(4'b0010);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_val($sformatf("pp0_cnt_%0d", i), bus.COUNT, 0);
      check_val($sformatf("pp0_dir_%0d", i), bus.DIR,   0);
    end

    // STOP and LOAD together while running: STOP wins, LOAD dropped.
    bus.LOAD_VAL = 4'd7;
    press(4'b1100);
    check_val("prio_run", bus.RUNNING, 0);
    check_val("prio_cnt", bus.COUNT,   0);
    bus.LOAD_VAL = 4'd15;
    press(4'b0100);
    check_val("load15", bus.COUNT, 15);
    press(4'b0001);
    check_val("step_wrap", bus.COUNT, 0);

    // Asynchronous reset mid-run at COUNT=6.
    bus.MODE     = 2'b00;
    bus.LOAD_VAL = 4'd6;
    press(4'b0100);
    press(4'b0010);
    check_val("pre_arst_run", bus.RUNNING, 1);
    check_val("pre_arst_cnt", bus.COUNT,   6);
    #3 RST_N = 1'b0;
    #1;
    check_val("arst_cnt", bus.COUNT,   0);
    check_val("arst_run", bus.RUNNING, 0);
    #2 RST_N = 1'b1;
    tick(10);
    check_val("post_arst_run",  bus.RUNNING, 0);
    check_val("post_arst_cnt",  bus.COUNT,   0);
    check_val("post_arst_done", bus.DONE,    0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
